// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions for the link-test transmitter and checker.
// Both ends call prbs7_advance64 so they agree on polynomial and bit order.
package prbs_pkg;

   localparam int         PRBS_WORD_W = 64;
   localparam int         PRBS7_TAP_A = 6;
   localparam int         PRBS7_TAP_B = 5;
   localparam logic [6:0] LOCKUP_SEED = 7'h7F;

   localparam logic [1:0] ERR_OFF      = 2'd0;
   localparam logic [1:0] ERR_SINGLE   = 2'd1;
   localparam logic [1:0] ERR_PERIODIC = 2'd2;

   typedef logic [1:0] err_state_t;
   localparam err_state_t ST_IDLE     = 2'd0;
   localparam err_state_t ST_ARMED    = 2'd1;
   localparam err_state_t ST_PERIODIC = 2'd2;

   typedef struct packed {
      logic [6:0]             state;
      logic [PRBS_WORD_W-1:0] word;
   } prbs7_step_t;

   // Word bit 0 is the earliest bit; every generated bit is also shifted into the state.
   function automatic prbs7_step_t prbs7_advance64(input logic [6:0] state_in);
      prbs7_step_t result;
      logic [6:0]  s;
      logic        b;
      s = state_in;
      result.word = '0;
      for (int i = 0; i < PRBS_WORD_W; i++) begin
         b = s[PRBS7_TAP_A] ^ s[PRBS7_TAP_B];
         s = {s[5:0], b};
         result.word[i] = b;
      end
      result.state = s;
      return result;
   endfunction

endpackage

// File: rtl/prbs7_word_gen.sv
// PRBS7 word generator: 7-bit LFSR advanced 64 bits per enabled cycle.
// Presents the word pair that becomes {cur, prev} on the coming clock edge.
module prbs7_word_gen
   import prbs_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       load_seed,
   input  logic [6:0]                 seed,
   output logic [2*PRBS_WORD_W-1:0]   pair,
   output logic                       pair_ok
);

   prbs7_step_t            step;
   logic [6:0]             lfsr;
   logic [PRBS_WORD_W-1:0] cur_word;
   logic                   cur_ok;

   always_comb step = prbs7_advance64(lfsr);

   // An all-zero seed would lock the LFSR, so it is replaced by the all-ones state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr     <= LOCKUP_SEED;
         cur_word <= '0;
         cur_ok   <= 1'b0;
      end else if (load_seed) begin
         lfsr     <= (seed == 7'h00) ? LOCKUP_SEED : seed;
         cur_word <= '0;
         cur_ok   <= 1'b0;
      end else if (enable) begin
         lfsr     <= step.state;
         cur_word <= step.word;
         cur_ok   <= 1'b1;
      end
   end

   assign pair    = {step.word, cur_word};
   assign pair_ok = cur_ok;

endmodule

// File: rtl/prbs7_tx_gen.sv
// PRBS7 transmit source with bit-slip window and single-shot/periodic error injection.
// Define PRBS7_TX_STATS_EN to build the frame_cnt/inj_count statistics counters.
module prbs7_tx_gen
   import prbs_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int SLIP_W = 6,
   parameter int PER_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load_seed,
   input  logic [6:0]        seed,
   input  logic [SLIP_W-1:0] slip_offset,
   input  logic [1:0]        err_mode,
   input  logic              err_trig,
   input  logic [PER_W-1:0]  err_period,
   input  logic [DATA_W-1:0] err_mask,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              inj_pulse,
   output logic [31:0]       frame_cnt,
   output logic [PER_W-1:0]  inj_count
);

   localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

   logic [2*DATA_W-1:0] pair;
   logic                pair_ok;
   logic [DATA_W-1:0]   window;
   logic                word_adv, mode_single, mode_periodic, trig_rise, inject;
   logic [PER_W-1:0]    reload;

   err_state_t          err_state, state_nxt;
   logic                pending, pending_nxt;
   logic                one_shot_done, done_nxt;
   logic                trig_d;
   logic [PER_W-1:0]    per_cnt, cnt_nxt;

   prbs7_word_gen u_word_gen (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load_seed (load_seed),
      .seed      (seed),
      .pair      (pair),
      .pair_ok   (pair_ok)
   );

   assign word_adv      = enable & ~load_seed & pair_ok;
   assign window        = DATA_W'(pair >> slip_offset);
   assign mode_single   = (err_mode == ERR_SINGLE);
   assign mode_periodic = (err_mode == ERR_PERIODIC);
   assign trig_rise     = err_trig & ~trig_d;
   assign reload        = (err_period == '0) ? PER_ONE : err_period;
   assign inject        = word_adv &
                          (((err_state == ST_ARMED) & mode_single & pending) |
                           ((err_state == ST_PERIODIC) & mode_periodic & (per_cnt <= PER_ONE)));

   // one_shot_done keeps IDLE from re-arming until err_mode has left single-shot.
   always_comb begin
      state_nxt   = err_state;
      pending_nxt = pending;
      done_nxt    = one_shot_done;
      cnt_nxt     = per_cnt;
      if (!mode_single) done_nxt = 1'b0;
      case (err_state)
         ST_IDLE: begin
            if (mode_single && !one_shot_done) begin
               state_nxt   = ST_ARMED;
               pending_nxt = 1'b0;
            end else if (mode_periodic) begin
               state_nxt = ST_PERIODIC;
               cnt_nxt   = reload;
            end
         end
         ST_ARMED: begin
            if (!mode_single) begin
               state_nxt   = ST_IDLE;
               pending_nxt = 1'b0;
            end else if (inject) begin
               state_nxt   = ST_IDLE;
               pending_nxt = 1'b0;
               done_nxt    = 1'b1;
            end else if (trig_rise) begin
               pending_nxt = 1'b1;
            end
         end
         ST_PERIODIC: begin
            if (!mode_periodic) state_nxt = ST_IDLE;
            else if (word_adv)  cnt_nxt   = (per_cnt <= PER_ONE) ? reload : per_cnt - PER_ONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_state     <= ST_IDLE;
         pending       <= 1'b0;
         one_shot_done <= 1'b0;
         trig_d        <= 1'b0;
         per_cnt       <= '0;
      end else begin
         err_state     <= state_nxt;
         pending       <= pending_nxt;
         one_shot_done <= done_nxt;
         trig_d        <= err_trig;
         per_cnt       <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         inj_pulse  <= 1'b0;
      end else begin
         dout_valid <= word_adv;
         inj_pulse  <= inject;
         if (word_adv) dout <= window ^ (inject ? err_mask : '0);
      end
   end

`ifdef PRBS7_TX_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= '0;
         inj_count <= '0;
      end else begin
         if (word_adv) frame_cnt <= frame_cnt + 32'd1;
         if (inject)   inj_count <= inj_count + PER_ONE;
      end
   end
`else
   assign frame_cnt = '0;
   assign inj_count = '0;
`endif

endmodule

// File: tb/tb_prbs7_tx_gen.sv
// Directed bench for prbs7_tx_gen: seeds, stream period, slip window, error injection, reset.
// Counter expectations follow whether PRBS7_TX_STATS_EN is defined for the build.
module tb_prbs7_tx_gen;
   import prbs_pkg::*;

   logic        clk = 1'b0;
   logic        reset, enable, load_seed, err_trig;
   logic [6:0]  seed;
   logic [5:0]  slip_offset;
   logic [1:0]  err_mode;
   logic [15:0] err_period;
   logic [63:0] err_mask;
   logic [63:0] dout;
   logic        dout_valid, inj_pulse;
   logic [31:0] frame_cnt;
   logic [15:0] inj_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] ref_words [0:199];
   logic [63:0] seen [0:129];
   int          slips [0:9] = '{1, 1, 1, 5, 0, 0, 63, 63, 32, 0};
   logic        trig_tab [0:7] = '{0, 1, 0, 0, 0, 1, 0, 0};
   logic [1:0]  mode_tab [0:7] = '{1, 1, 1, 0, 1, 1, 1, 1};
   logic        inj_tab  [0:7] = '{0, 0, 0, 0, 0, 0, 1, 0};

`ifdef PRBS7_TX_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   prbs7_tx_gen dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .load_seed   (load_seed),
      .seed        (seed),
      .slip_offset (slip_offset),
      .err_mode    (err_mode),
      .err_trig    (err_trig),
      .err_period  (err_period),
      .err_mask    (err_mask),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .inj_pulse   (inj_pulse),
      .frame_cnt   (frame_cnt),
      .inj_count   (inj_count)
   );

   always #5 clk = ~clk;

   task step;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Bit-serial reference stream starting from the all-ones state.
   task build_model;
      logic [6:0] s;
      logic       b;
      s = 7'h7F;
      for (int w = 0; w < 200; w++) begin
         for (int i = 0; i < 64; i++) begin
            b = s[6] ^ s[5];
            s = {s[5:0], b};
            ref_words[w][i] = b;
         end
      end
   endtask

   task test_reset;
      n_checks++; if (dout !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_dout: got %h expected %h", dout, 64'h0); end
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", dout_valid); end
      n_checks++; if (inj_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_inj: got %b expected 0", inj_pulse); end
      n_checks++; if (frame_cnt !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      n_checks++; if (inj_count !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_inj_count: got %0d expected 0", inj_count); end
      reset = 1'b1;
      step;
   endtask

   task test_seed_and_period;
      err_mode = ERR_OFF; slip_offset = 6'd0;
      seed = 7'h00; load_seed = 1'b1; enable = 1'b0;
      step;
      load_seed = 1'b0; enable = 1'b1;
      step;
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_early: valid %b expected 0", dout_valid); end
      step;
      n_checks++; if (dout[15:0] !== 16'h3040) begin n_fail++; $display("[TB] FAIL first_word_lsbs: got %h expected 3040", dout[15:0]); end
      for (int j = 0; j < 130; j++) begin
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== ref_words[j]) begin
            n_fail++; $display("[TB] FAIL seed0_word%0d: got %h valid %b expected %h valid 1", j, dout, dout_valid, ref_words[j]);
         end
         seen[j] = dout;
         if (j >= 127) begin
            n_checks++;
            if (seen[j] !== seen[j-127]) begin n_fail++; $display("[TB] FAIL period127_word%0d: got %h expected %h", j, seen[j], seen[j-127]); end
         end
         if (j == 129) enable = 1'b0;
         step;
      end
      n_checks++;
      if (dout_valid !== 1'b0 || dout !== ref_words[129]) begin
         n_fail++; $display("[TB] FAIL hold: got %h valid %b expected %h valid 0", dout, dout_valid, ref_words[129]);
      end
      seed = 7'h7F; load_seed = 1'b1;
      step;
      load_seed = 1'b0; enable = 1'b1;
      step;
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL seed7f_latency: valid %b expected 0", dout_valid); end
      step;
      for (int j = 0; j < 10; j++) begin
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== ref_words[j]) begin
            n_fail++; $display("[TB] FAIL seed7f_word%0d: got %h valid %b expected %h valid 1", j, dout, dout_valid, ref_words[j]);
         end
         step;
      end
      enable = 1'b0;
      step;
   endtask

   task test_slip;
      logic [127:0] p;
      seed = 7'h7F; load_seed = 1'b1; enable = 1'b0;
      step;
      load_seed = 1'b0; enable = 1'b1;
      step;
      for (int j = 0; j < 10; j++) begin
         slip_offset = 6'(slips[j]);
         step;
         p = {ref_words[j+1], ref_words[j]} >> slips[j];
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== p[63:0]) begin
            n_fail++; $display("[TB] FAIL slip%0d_word%0d: got %h valid %b expected %h valid 1", slips[j], j, dout, dout_valid, p[63:0]);
         end
      end
      enable = 1'b0; slip_offset = 6'd0;
      step;
   endtask

   task test_periodic;
      int          pulses;
      logic [63:0] exp;
      pulses = 0;
      err_mode = ERR_PERIODIC; err_period = 16'd4; err_mask = 64'h1;
      enable = 1'b1; slip_offset = 6'd0; err_trig = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step;
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL per_latency: valid %b expected 0", dout_valid); end
      for (int j = 1; j <= 40; j++) begin
         step;
         exp = ref_words[j-1] ^ ((j % 4 == 0) ? 64'h1 : 64'h0);
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== exp || inj_pulse !== (j % 4 == 0)) begin
            n_fail++; $display("[TB] FAIL per_word%0d: got %h inj %b expected %h inj %b", j, dout, inj_pulse, exp, (j % 4 == 0));
         end
         if (inj_pulse === 1'b1) pulses++;
         if (j == 40) enable = 1'b0;
      end
      n_checks++; if (pulses != 10) begin n_fail++; $display("[TB] FAIL per_pulses: got %0d expected 10", pulses); end
      n_checks++; if (inj_count !== (STATS_ON ? 16'd10 : 16'd0)) begin n_fail++; $display("[TB] FAIL per_inj_count: got %0d expected %0d", inj_count, STATS_ON ? 10 : 0); end
      n_checks++; if (frame_cnt !== (STATS_ON ? 32'd40 : 32'd0)) begin n_fail++; $display("[TB] FAIL per_frame_cnt: got %0d expected %0d", frame_cnt, STATS_ON ? 40 : 0); end
      step;
      n_checks++;
      if (dout_valid !== 1'b0 || inj_pulse !== 1'b0 || dout !== (ref_words[39] ^ 64'h1)) begin
         n_fail++; $display("[TB] FAIL per_idle: got %h valid %b inj %b expected %h valid 0 inj 0", dout, dout_valid, inj_pulse, ref_words[39] ^ 64'h1);
      end
      err_mode = ERR_OFF;
      step;
   endtask

   task test_single_shot;
      logic [63:0] mask;
      logic [63:0] exp;
      mask = 64'hFFFF_0000_0000_0000;
      err_mode = ERR_SINGLE; err_mask = mask; enable = 1'b0; err_trig = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step;
      err_trig = 1'b1; step;
      err_trig = 1'b0; step;
      err_trig = 1'b1; step;
      err_trig = 1'b0; step;
      enable = 1'b1;
      step;
      n_checks++; if (dout_valid !== 1'b0 || inj_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL ss_latency: valid %b inj %b expected 0 0", dout_valid, inj_pulse); end
      step;
      n_checks++;
      if (dout_valid !== 1'b1 || inj_pulse !== 1'b1 || dout !== (ref_words[0] ^ mask)) begin
         n_fail++; $display("[TB] FAIL ss_first: got %h inj %b expected %h inj 1", dout, inj_pulse, ref_words[0] ^ mask);
      end
      n_checks++; if (dut.err_state !== ST_IDLE) begin n_fail++; $display("[TB] FAIL ss_fsm_idle: got %0d expected %0d", dut.err_state, ST_IDLE); end
      for (int j = 0; j < 8; j++) begin
         err_trig = trig_tab[j]; err_mode = mode_tab[j];
         step;
         exp = ref_words[j+1] ^ (inj_tab[j] ? mask : 64'h0);
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== exp || inj_pulse !== inj_tab[j]) begin
            n_fail++; $display("[TB] FAIL ss_word%0d: got %h inj %b expected %h inj %b", j + 2, dout, inj_pulse, exp, inj_tab[j]);
         end
      end
      n_checks++; if (inj_count !== (STATS_ON ? 16'd2 : 16'd0)) begin n_fail++; $display("[TB] FAIL ss_inj_count: got %0d expected %0d", inj_count, STATS_ON ? 2 : 0); end
      n_checks++; if (frame_cnt !== (STATS_ON ? 32'd9 : 32'd0)) begin n_fail++; $display("[TB] FAIL ss_frame_cnt: got %0d expected %0d", frame_cnt, STATS_ON ? 9 : 0); end
      enable = 1'b0; err_mode = ERR_OFF;
      step;
   endtask

   task test_reset_mid_stream;
      logic [63:0] exp;
      err_mode = ERR_PERIODIC; err_period = 16'd4; err_mask = 64'h1; enable = 1'b1;
      repeat (6) step;
      reset = 1'b0;
      #1;
      n_checks++;
      if (dout !== 64'h0 || dout_valid !== 1'b0 || inj_pulse !== 1'b0) begin
         n_fail++; $display("[TB] FAIL mid_reset_out: got %h valid %b inj %b expected 0 0 0", dout, dout_valid, inj_pulse);
      end
      n_checks++;
      if (frame_cnt !== 32'h0 || inj_count !== 16'h0) begin
         n_fail++; $display("[TB] FAIL mid_reset_cnt: got %0d/%0d expected 0/0", frame_cnt, inj_count);
      end
      @(negedge clk);
      reset = 1'b1;
      step;
      n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_restart_latency: valid %b expected 0", dout_valid); end
      for (int j = 1; j <= 5; j++) begin
         step;
         exp = ref_words[j-1] ^ ((j == 4) ? 64'h1 : 64'h0);
         n_checks++;
         if (dout_valid !== 1'b1 || dout !== exp || inj_pulse !== (j == 4)) begin
            n_fail++; $display("[TB] FAIL mid_word%0d: got %h inj %b expected %h inj %b", j, dout, inj_pulse, exp, (j == 4));
         end
      end
      n_checks++; if (frame_cnt !== (STATS_ON ? 32'd5 : 32'd0)) begin n_fail++; $display("[TB] FAIL mid_frame_cnt: got %0d expected %0d", frame_cnt, STATS_ON ? 5 : 0); end
      n_checks++; if (inj_count !== (STATS_ON ? 16'd1 : 16'd0)) begin n_fail++; $display("[TB] FAIL mid_inj_count: got %0d expected %0d", inj_count, STATS_ON ? 1 : 0); end
      enable = 1'b0; err_mode = ERR_OFF;
      step;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; load_seed = 1'b0; err_trig = 1'b0;
      seed = 7'h7F; slip_offset = 6'd0; err_mode = ERR_OFF;
      err_period = 16'd1; err_mask = 64'h0;
      build_model;
      @(negedge clk);
      @(negedge clk);
      test_reset;
      test_seed_and_period;
      test_slip;
      test_periodic;
      test_single_shot;
      test_reset_mid_stream;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/prbs7_tx_gen.md
Name: prbs7_tx_gen

Overview:
- Transmit-side PRBS7 pattern source for the SERDES link test. Generates 64 PRBS7 bits per clock to feed the serializer.
- Models lane misalignment with a programmable bit-slip window and injects controlled bit errors (single-shot or periodic).
- Its output stream is what the receive-side aligner/PRBS7 checker locks onto and counts errors against.

Parameters:
- DATA_W, 64, word width; fixed at 64, other values unsupported.
- SLIP_W, 6, width of slip_offset (0..DATA_W-1).
- PER_W, 16, width of err_period and inj_count.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- enable  input  1  1 = advance generator one word per cycle
- load_seed  input  1  load seed into LFSR this cycle
- seed  input  7  LFSR seed (7'h00 substituted by 7'h7F)
- slip_offset  input  SLIP_W  bit offset of output window
- err_mode  input  2  0 off, 1 single-shot, 2 periodic, 3 reserved (= off)
- err_trig  input  1  single-shot trigger (rising edge)
- err_period  input  PER_W  valid words between periodic injections (0 treated as 1)
- err_mask  input  DATA_W  XOR pattern applied on injected word
- dout  output  DATA_W  transmitted word
- dout_valid  output  1  dout carries a new word
- inj_pulse  output  1  1 on the cycle dout carries an injected error
- frame_cnt  output  32  valid words sent (stats feature)
- inj_count  output  PER_W  injections performed (stats feature)

Behaviour:
- Reset (reset=0): LFSR=7'h7F, prev word=0, dout=0, dout_valid=0, inj_pulse=0, counters=0, FSM=IDLE. Takes effect immediately, mid-word included; no partial word is emitted after release.
- LFSR: state s[6:0]. Per bit: b=s[6]^s[5], s<={s[5:0],b}, emitted bit=b. A word is 64 consecutive bits, bit 0 earliest. Next state is the 64-step advance, computed combinationally in one cycle.
- Stream period: 127 bits. Word k+127 equals word k.
- load_seed has priority over enable. That cycle: LFSR <= (seed==0 ? 7'h7F : seed), prev word cleared, dout_valid=0.
- enable=1: gen word registered into cur; cur moves to prev.
- Output register: dout <= ({cur,prev} >> slip_offset)[63:0] ^ (inject ? err_mask : 0).
  - slip_offset=0 gives dout=prev.
  - Latency: first valid dout 2 cycles after the first enabled cycle following reset/load_seed.
- dout_valid=1 only when that output register updated from two generated words.
- enable=0: LFSR, cur, prev and dout hold; dout_valid=0; period counter holds.
- slip_offset change applies to the next registered dout. No flush, no gap in dout_valid.
- Error FSM, states IDLE, ARMED, PERIODIC:
  - IDLE -> ARMED when err_mode=1. IDLE -> PERIODIC when err_mode=2. Reload counter := max(err_period,1).
  - ARMED: rising err_trig latched. Injection goes on the next valid word, then back to IDLE. It re-arms only after err_mode leaves 1 and returns.
  - PERIODIC: counter decrements per valid word. At 1, that word is injected and the counter is reloaded. err_period changes take effect on reload.
  - Any state -> IDLE when err_mode becomes 0 or 3. A pending trigger is dropped.
- Trigger while not enabled stays pending until the next valid word.
- Trigger while already ARMED-pending is ignored (one injection).
- inj_pulse is aligned with dout. inj_count increments per injection, even with err_mask=0. Wraps at 2^PER_W.
- frame_cnt increments per valid word and wraps at 2^32.

Optional Feature:
- PRBS7_TX_STATS_EN.
- Defined: frame_cnt and inj_count implemented as above.
- Undefined: both outputs tied to 0, counters not synthesized. inj_pulse is still produced.

Decomposition:
- Shared package prbs_pkg holds:
  - PRBS7 polynomial taps and LOCKUP_SEED=7'h7F;
  - err_mode encodings (ERR_OFF, ERR_SINGLE, ERR_PERIODIC);
  - FSM state typedef;
  - the 64-step PRBS7 advance function. The checker uses the same function, so both ends agree on bit order.
- One sub-module: prbs7_word_gen (LFSR plus 64-bit word, load/enable). Slip, injection and stats stay in the top.

Test Plan:
- Seed 7'h00 vs seed 7'h7F, enable held, slip 0 -> identical dout streams; word k+127 equals word k; dout_valid first high 2 cycles after enable.
- slip_offset=1 -> dout[62:0]=prev[63:1], dout[63]=cur[0] against the model. Switch to 0 mid-stream -> no dout_valid gap, next word exactly prev.
- err_mode=2, err_period=4, err_mask=64'h1, 40 valid words -> bit 0 flipped on words 4,8,...,40; inj_pulse on those 10 words; inj_count=10.
- err_mode=1, err_trig pulsed twice while enable=0 then enable=1 -> exactly one injected word (first valid) with err_mask=64'hFFFF_0000_0000_0000; FSM returns to IDLE.
- reset pulled low mid-stream with err_mode=2 -> dout=0 and dout_valid=0 immediately; after release the stream restarts from LFSR 7'h7F; counters=0.
- Build without PRBS7_TX_STATS_EN, repeat the periodic test -> frame_cnt=0 and inj_count=0; inj_pulse unchanged.
